// File: rtl/sprite_palette_pkg.sv
// Shared types and constants for the sprite/tile palette lookup and its fade controller.
package sprite_palette_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FADE_OUT = 2'd1,
        DARK     = 2'd2,
        FADE_IN  = 2'd3
    } fade_state_t;

    localparam logic [1:0] FADE_NONE    = 2'b00;
    localparam logic [1:0] FADE_OUT_CMD = 2'b01;
    localparam logic [1:0] FADE_IN_CMD  = 2'b10;

    localparam int unsigned DEFAULT_PAL_N = 16;
    localparam int unsigned DEFAULT_RGB_W = 12;

    // Boot palette 0, {R,G,B}; entry 0 is the transparent slot.
    localparam logic [DEFAULT_PAL_N-1:0][DEFAULT_RGB_W-1:0] DEFAULT_PAL = {
        12'h222, 12'h888, 12'hEEE, 12'h357,
        12'hC60, 12'h6B8, 12'hA3F, 12'hFD0,
        12'h4A2, 12'h8CF, 12'hF93, 12'h00F,
        12'h0F0, 12'hF00, 12'hFFF, 12'h000
    };

    // Default palette entry, zero beyond the 16 defined colours.
    function automatic logic [DEFAULT_RGB_W-1:0] default_entry(input int unsigned i);
        return (i < DEFAULT_PAL_N) ? DEFAULT_PAL[i[3:0]] : '0;
    endfunction

    // Palette-select width, never narrower than one bit.
    function automatic int unsigned pal_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sprite_palette_lut_if.sv
// Pixel request, palette write, fade command and coloured-pixel result bundle.
interface sprite_palette_lut_if
    import sprite_palette_pkg::*;
#(
    parameter int unsigned IDX_W   = 4,
    parameter int unsigned NUM_PAL = 4,
    parameter int unsigned COLOR_W = 4
);
    localparam int unsigned PAL_W = pal_width(NUM_PAL);
    localparam int unsigned RGB_W = 3 * COLOR_W;

    logic               in_valid;
    logic [IDX_W-1:0]   in_idx;
    logic [PAL_W-1:0]   in_pal;
    logic               wr_en;
    logic [PAL_W-1:0]   wr_pal;
    logic [IDX_W-1:0]   wr_idx;
    logic [RGB_W-1:0]   wr_rgb;
    logic [1:0]         fade_cmd;
    logic               out_valid;
    logic [COLOR_W-1:0] red;
    logic [COLOR_W-1:0] green;
    logic [COLOR_W-1:0] blue;
    logic               out_transp;
    logic               fade_busy;
    logic [COLOR_W-1:0] fade_level;

    modport master (
        output in_valid, in_idx, in_pal,
        output wr_en, wr_pal, wr_idx, wr_rgb,
        output fade_cmd,
        input  out_valid, red, green, blue, out_transp,
        input  fade_busy, fade_level
    );

    modport slave (
        input  in_valid, in_idx, in_pal,
        input  wr_en, wr_pal, wr_idx, wr_rgb,
        input  fade_cmd,
        output out_valid, red, green, blue, out_transp,
        output fade_busy, fade_level
    );

endinterface

// File: rtl/palette_fade_ctrl.sv
// Global fade-to/from-black sequencer: state, step prescaler and darkening level.
module palette_fade_ctrl
    import sprite_palette_pkg::*;
#(
    parameter int unsigned COLOR_W  = 4,
    parameter int unsigned FADE_DIV = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         fade_cmd,
    output logic               fade_busy,
    output logic [COLOR_W-1:0] fade_level
);

    localparam int unsigned        PRESC_W    = 8;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(FADE_DIV - 1);
    localparam logic [COLOR_W-1:0] L_MAX      = '1;
    localparam logic [COLOR_W-1:0] L_PEN_UP   = L_MAX - COLOR_W'(1);
    localparam logic [COLOR_W-1:0] L_PEN_DOWN = COLOR_W'(1);

    fade_state_t        state;
    logic [PRESC_W-1:0] presc;
    logic               go_out_c;
    logic               go_in_c;
    logic               step_c;

    always_comb begin : cmd_decode_p
        go_out_c = (fade_cmd == FADE_OUT_CMD) && ((state == IDLE) || (state == FADE_IN));
        go_in_c  = (fade_cmd == FADE_IN_CMD)  && ((state == DARK) || (state == FADE_OUT));
        step_c   = (presc == PRESC_LAST);
    end

    // Accepted commands restart the prescaler; level moves once per FADE_DIV edges.
    always_ff @(posedge clk or posedge rst) begin : fsm_p
        if (rst) begin
            state      <= IDLE;
            presc      <= '0;
            fade_level <= '0;
            fade_busy  <= 1'b0;
        end else if (go_out_c) begin
            presc <= '0;
            if (fade_level == L_MAX) begin
                state     <= DARK;
                fade_busy <= 1'b0;
            end else begin
                state     <= FADE_OUT;
                fade_busy <= 1'b1;
            end
        end else if (go_in_c) begin
            presc <= '0;
            if (fade_level == '0) begin
                state     <= IDLE;
                fade_busy <= 1'b0;
            end else begin
                state     <= FADE_IN;
                fade_busy <= 1'b1;
            end
        end else begin
            case (state)
                FADE_OUT: begin
                    if (step_c) begin
                        presc      <= '0;
                        fade_level <= fade_level + 1'b1;
                        if (fade_level == L_PEN_UP) begin
                            state     <= DARK;
                            fade_busy <= 1'b0;
                        end
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end
                FADE_IN: begin
                    if (step_c) begin
                        presc      <= '0;
                        fade_level <= fade_level - 1'b1;
                        if (fade_level == L_PEN_DOWN) begin
                            state     <= IDLE;
                            fade_busy <= 1'b0;
                        end
                    end else begin
                        presc <= presc + 1'b1;
                    end
                end
                default: presc <= '0;
            endcase
        end
    end

endmodule

// File: rtl/sprite_palette_lut.sv
// Multi-palette colour lookup: two-stage registered pipeline, transparent index 0,
// and global saturating fade applied to every looked-up colour.
module sprite_palette_lut
    import sprite_palette_pkg::*;
#(
    parameter int unsigned IDX_W    = 4,
    parameter int unsigned NUM_PAL  = 4,
    parameter int unsigned COLOR_W  = 4,
    parameter int unsigned FADE_DIV = 4
) (
    input  logic                clk,
    input  logic                rst,
    sprite_palette_lut_if.slave bus
);

    localparam int unsigned PAL_W = pal_width(NUM_PAL);
    localparam int unsigned DEPTH = 1 << IDX_W;
    localparam int unsigned RGB_W = 3 * COLOR_W;

    logic [RGB_W-1:0] pal_mem [NUM_PAL][DEPTH];

    logic             s1_valid;
    logic [IDX_W-1:0] s1_idx;
    logic [PAL_W-1:0] s1_pal;

    logic             wr_ok_c;
    logic             rd_ok_c;
    logic [RGB_W-1:0] rd_rgb_c;
    logic [RGB_W-1:0] faded_c;

    function automatic logic [COLOR_W-1:0] fade_chan(input logic [COLOR_W-1:0] c,
                                                     input logic [COLOR_W-1:0] l);
        return (c > l) ? COLOR_W'(c - l) : '0;
    endfunction

    palette_fade_ctrl #(
        .COLOR_W  (COLOR_W),
        .FADE_DIV (FADE_DIV)
    ) u_fade (
        .clk        (clk),
        .rst        (rst),
        .fade_cmd   (bus.fade_cmd),
        .fade_busy  (bus.fade_busy),
        .fade_level (bus.fade_level)
    );

    // Selects beyond NUM_PAL only exist for non-power-of-two palette counts.
    always_comb begin : range_p
        wr_ok_c = bus.wr_en && ({1'b0, bus.wr_pal} < (PAL_W + 1)'(NUM_PAL));
        rd_ok_c = ({1'b0, s1_pal} < (PAL_W + 1)'(NUM_PAL));
    end

    // Colour table; reset restores the boot palette and blanks the rest.
    always_ff @(posedge clk or posedge rst) begin : table_p
        if (rst) begin
            for (int p = 0; p < int'(NUM_PAL); p++) begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    pal_mem[p][i] <= (p == 0) ? RGB_W'(default_entry(i)) : '0;
                end
            end
        end else if (wr_ok_c) begin
            pal_mem[bus.wr_pal][bus.wr_idx] <= bus.wr_rgb;
        end
    end

    always_ff @(posedge clk or posedge rst) begin : stage1_p
        if (rst) begin
            s1_valid <= 1'b0;
            s1_idx   <= '0;
            s1_pal   <= '0;
        end else begin
            s1_valid <= bus.in_valid;
            s1_idx   <= bus.in_idx;
            s1_pal   <= bus.in_pal;
        end
    end

    // Table read sees pre-write contents when a write lands on the same edge.
    always_comb begin : read_p
        rd_rgb_c = '0;
        if (rd_ok_c) begin
            rd_rgb_c = pal_mem[s1_pal][s1_idx];
        end
        faded_c = {fade_chan(rd_rgb_c[RGB_W-1 -: COLOR_W],   bus.fade_level),
                   fade_chan(rd_rgb_c[2*COLOR_W-1 -: COLOR_W], bus.fade_level),
                   fade_chan(rd_rgb_c[COLOR_W-1:0],          bus.fade_level)};
    end

    // Colour and transparency hold their last value across invalid cycles.
    always_ff @(posedge clk or posedge rst) begin : stage2_p
        if (rst) begin
            bus.out_valid  <= 1'b0;
            bus.out_transp <= 1'b0;
            bus.red        <= '0;
            bus.green      <= '0;
            bus.blue       <= '0;
        end else if (s1_valid) begin
            bus.out_valid <= 1'b1;
            if (s1_idx == '0) begin
                bus.out_transp <= 1'b1;
                bus.red        <= '0;
                bus.green      <= '0;
                bus.blue       <= '0;
            end else begin
                bus.out_transp <= 1'b0;
                bus.red        <= faded_c[RGB_W-1 -: COLOR_W];
                bus.green      <= faded_c[2*COLOR_W-1 -: COLOR_W];
                bus.blue       <= faded_c[COLOR_W-1:0];
            end
        end else begin
            bus.out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sprite_palette_lut.sv
// Directed plus randomized bench for sprite_palette_lut against a cycle-level reference model.
module tb_sprite_palette_lut;
    import sprite_palette_pkg::*;

    localparam int IDX_W    = 4;
    localparam int NUM_PAL  = 4;
    localparam int COLOR_W  = 4;
    localparam int FADE_DIV = 4;
    localparam int L_MAX    = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sprite_palette_lut_if #(.IDX_W(IDX_W), .NUM_PAL(NUM_PAL), .COLOR_W(COLOR_W)) bus ();

    sprite_palette_lut #(
        .IDX_W(IDX_W), .NUM_PAL(NUM_PAL), .COLOR_W(COLOR_W), .FADE_DIV(FADE_DIV)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [11:0] mem [NUM_PAL][16];
    bit          m_s1v;
    int          m_s1i, m_s1p;
    bit          e_valid, e_transp;
    logic [11:0] e_rgb;
    int          mL, cyc, cmd_cyc, L0, dir;   // dir: 0 none, 1 darkening, 2 brightening

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] fade_rgb(input logic [11:0] c, input int l);
        int r, g, b;
        r = int'(c[11:8]) - l;
        g = int'(c[7:4]) - l;
        b = int'(c[3:0]) - l;
        if (r < 0) r = 0;
        if (g < 0) g = 0;
        if (b < 0) b = 0;
        return {r[3:0], g[3:0], b[3:0]};
    endfunction

    // Level as a closed form of edges elapsed since the last accepted command.
    function automatic int model_level();
        int s;
        s = (cyc - cmd_cyc) / FADE_DIV;
        if (dir == 1) return (L0 + s > L_MAX) ? L_MAX : L0 + s;
        if (dir == 2) return (L0 - s < 0) ? 0 : L0 - s;
        return 0;
    endfunction

    task automatic model_reset();
        for (int p = 0; p < NUM_PAL; p++)
            for (int i = 0; i < 16; i++)
                mem[p][i] = (p == 0) ? DEFAULT_PAL[4'(i)] : 12'h000;
        m_s1v = 0; m_s1i = 0; m_s1p = 0;
        e_valid = 0; e_transp = 0; e_rgb = 12'h000;
        mL = 0; cyc = 0; cmd_cyc = 0; L0 = 0; dir = 0;
    endtask

    task automatic drive_px(input bit v, input int pal, input int idx);
        bus.in_valid = v;
        bus.in_pal   = 2'(pal);
        bus.in_idx   = 4'(idx);
    endtask

    task automatic drive_wr(input bit en, input int pal, input int idx, input logic [11:0] rgb);
        bus.wr_en  = en;
        bus.wr_pal = 2'(pal);
        bus.wr_idx = 4'(idx);
        bus.wr_rgb = rgb;
    endtask

    // One clock edge: advance the model with the inputs sampled there, then compare.
    task automatic step();
        int prev_l;
        bit busy;
        @(posedge clk);
        prev_l = mL;
        if (m_s1v) begin
            e_valid = 1;
            if (m_s1i == 0) begin
                e_transp = 1;
                e_rgb    = 12'h000;
            end else begin
                e_transp = 0;
                e_rgb    = (m_s1p < NUM_PAL) ? fade_rgb(mem[m_s1p][m_s1i], prev_l) : 12'h000;
            end
        end else begin
            e_valid = 0;
        end
        if (bus.wr_en && int'(bus.wr_pal) < NUM_PAL) mem[bus.wr_pal][bus.wr_idx] = bus.wr_rgb;
        m_s1v = bus.in_valid;
        m_s1i = int'(bus.in_idx);
        m_s1p = int'(bus.in_pal);
        cyc++;
        if (bus.fade_cmd == FADE_OUT_CMD && dir != 1) begin
            dir = 1; L0 = mL; cmd_cyc = cyc;
        end else if (bus.fade_cmd == FADE_IN_CMD && dir == 1) begin
            dir = 2; L0 = mL; cmd_cyc = cyc;
        end
        mL = model_level();
        busy = (dir == 1 && mL < L_MAX) || (dir == 2 && mL > 0);
        #1;
        check("out_valid", 32'(bus.out_valid), 32'(e_valid));
        check("out_transp", 32'(bus.out_transp), 32'(e_transp));
        check("rgb", 32'({bus.red, bus.green, bus.blue}), 32'(e_rgb));
        check("fade_level", 32'(bus.fade_level), 32'(mL));
        check("fade_busy", 32'(bus.fade_busy), 32'(busy));
    endtask

    task automatic rstep();
        drive_px($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
        step();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_rgb"}, 32'({bus.red, bus.green, bus.blue}), 32'h000);
        check({tag, "_transp"}, 32'(bus.out_transp), 32'd0);
        check({tag, "_busy"}, 32'(bus.fade_busy), 32'd0);
        check({tag, "_level"}, 32'(bus.fade_level), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        drive_px(0, 0, 0);
        drive_wr(0, 0, 0, 12'h000);
        bus.fade_cmd = FADE_NONE;
        model_reset();
        #12;
        check_reset_state("reset");
        #1 rst = 1'b0;

        // Boot palette lookup and transparent index
        drive_px(1, 0, 5); step();
        drive_px(1, 0, 0); step();
        check("boot_idx5", 32'({bus.red, bus.green, bus.blue}), 32'h0F93);
        drive_px(0, 0, 0); step();
        check("idx0_transp", 32'(bus.out_transp), 32'd1);
        check("idx0_rgb", 32'({bus.red, bus.green, bus.blue}), 32'h000);
        step();
        check("gap_valid", 32'(bus.out_valid), 32'd0);

        // Same-edge write and read of pal 2 idx 3, then the follow-up request
        drive_px(1, 2, 3); step();
        drive_wr(1, 2, 3, 12'hA5C); drive_px(1, 2, 3); step();
        check("rbw_old", 32'({bus.red, bus.green, bus.blue}), 32'h000);
        drive_wr(0, 0, 0, 12'h000); drive_px(0, 0, 0); step();
        check("rbw_new", 32'({bus.red, bus.green, bus.blue}), 32'hA5C);
        check("rbw_new_valid", 32'(bus.out_valid), 32'd1);

        // Streaming with an in_valid gap and a second burst
        for (int n = 0; n < 32; n++) begin
            drive_px(1, int'($urandom_range(0, 3)), int'($urandom_range(0, 15)));
            step();
        end
        drive_px(0, 0, 0);
        repeat (3) step();
        for (int n = 0; n < 8; n++) begin
            drive_px(1, 2, int'($urandom_range(0, 15)));
            step();
        end

        // Fade out over pal 0 idx 5 (0xF93)
        drive_px(1, 0, 5);
        bus.fade_cmd = FADE_OUT_CMD; step(); bus.fade_cmd = FADE_NONE;
        repeat (3) step();
        check("fo_level0", 32'(bus.fade_level), 32'd0);
        step();
        check("fo_level1", 32'(bus.fade_level), 32'd1);
        repeat (16) step();
        check("fo_level5", 32'(bus.fade_level), 32'd5);
        step();
        check("fo_rgb_l5", 32'({bus.red, bus.green, bus.blue}), 32'hA40);
        repeat (38) step();
        check("fo_level14", 32'(bus.fade_level), 32'd14);
        check("fo_busy14", 32'(bus.fade_busy), 32'd1);
        step();
        check("dark_level", 32'(bus.fade_level), 32'd15);
        check("dark_busy", 32'(bus.fade_busy), 32'd0);
        step();
        check("dark_rgb", 32'({bus.red, bus.green, bus.blue}), 32'h000);

        // Fade back in from DARK, out again to 7, reverse, finish at IDLE
        bus.fade_cmd = FADE_IN_CMD; step(); bus.fade_cmd = FADE_NONE;
        repeat (60) rstep();
        check("fi_idle_level", 32'(bus.fade_level), 32'd0);
        check("fi_idle_busy", 32'(bus.fade_busy), 32'd0);
        bus.fade_cmd = FADE_OUT_CMD; rstep(); bus.fade_cmd = FADE_NONE;
        repeat (28) rstep();
        check("rev_level7", 32'(bus.fade_level), 32'd7);
        bus.fade_cmd = FADE_IN_CMD; rstep(); bus.fade_cmd = FADE_NONE;
        repeat (3) rstep();
        check("rev_hold7", 32'(bus.fade_level), 32'd7);
        rstep();
        check("rev_level6", 32'(bus.fade_level), 32'd6);
        check("rev_busy", 32'(bus.fade_busy), 32'd1);
        repeat (24) rstep();
        check("rev_idle_level", 32'(bus.fade_level), 32'd0);
        check("rev_idle_busy", 32'(bus.fade_busy), 32'd0);
        bus.fade_cmd = FADE_IN_CMD; rstep(); bus.fade_cmd = FADE_NONE;
        repeat (8) rstep();
        check("ign_level", 32'(bus.fade_level), 32'd0);
        check("ign_busy", 32'(bus.fade_busy), 32'd0);

        // Randomized writes, lookups and occasional fade commands
        for (int n = 0; n < 400; n++) begin
            drive_wr($urandom_range(0, 3) == 0, int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 15)), 12'($urandom));
            bus.fade_cmd = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : FADE_NONE;
            rstep();
        end
        drive_wr(0, 0, 0, 12'h000);
        bus.fade_cmd = FADE_NONE;

        // Reset in the middle of a fade with pixels in flight
        drive_wr(1, 2, 3, 12'hA5C); step(); drive_wr(0, 0, 0, 12'h000);
        if (dir == 1) begin
            bus.fade_cmd = FADE_IN_CMD; rstep(); bus.fade_cmd = FADE_NONE;
            repeat (64) rstep();
        end
        bus.fade_cmd = FADE_OUT_CMD; rstep(); bus.fade_cmd = FADE_NONE;
        repeat (9) rstep();
        drive_px(1, 0, 5); step();
        check("pre_rst_busy", 32'(bus.fade_busy), 32'd1);
        drive_px(0, 0, 0);
        rst = 1'b1;
        #1;
        check_reset_state("midrst");
        #2 rst = 1'b0;
        model_reset();
        drive_px(1, 2, 3); step();
        drive_px(1, 0, 5); step();
        check("post_rst_pal2", 32'({bus.red, bus.green, bus.blue}), 32'h000);
        drive_px(0, 0, 0); step();
        check("post_rst_pal0", 32'({bus.red, bus.green, bus.blue}), 32'hF93);
        repeat (4) rstep();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_palette_lut.md
# sprite_palette_lut

Runtime-loadable, multi-palette colour lookup for the sprite and tile pixel path. Maps a per-pixel colour index plus a palette select to 12-bit RGB through a registered two-stage pipeline, flags the transparent index, and applies a global timed fade-to-black and fade-from-black for room transitions. It sits between the sprite/tile ROM readers and the VGA colour mux, and is reloadable by the game-logic FSM between frames.

## Interface
Parameters:
- IDX_W, 4, colour-index width; each palette holds 2^IDX_W entries
- NUM_PAL, 4, number of palettes; select width PAL_W = $clog2(NUM_PAL), minimum 1
- COLOR_W, 4, bits per colour channel
- FADE_DIV, 4, clock cycles per fade step, range 1..255

Ports:
- Clk, in, 1, system clock
- Reset, in, 1, asynchronous, active-high; clears all state
- in_valid, in, 1, pixel request valid
- in_idx, in, IDX_W, colour index
- in_pal, in, PAL_W, palette select
- wr_en, in, 1, palette entry write strobe
- wr_pal, in, PAL_W, write palette
- wr_idx, in, IDX_W, write entry
- wr_rgb, in, 3*COLOR_W, colour to store, ordered {R,G,B}
- fade_cmd, in, 2, 00 none, 01 fade out, 10 fade in, 11 ignored
- out_valid, out, 1, output pixel valid
- red/green/blue, out, COLOR_W each, faded colour
- out_transp, out, 1, pixel is transparent (index 0)
- fade_busy, out, 1, high in FADE_OUT or FADE_IN
- fade_level, out, COLOR_W, current darkening level

## Operation
- Storage: NUM_PAL × 2^IDX_W registers of 3*COLOR_W bits. Reset loads palette 0 from the package constant DEFAULT_PAL and all other palettes with zero.
- Writes: when wr_en is high at a rising edge, entry [wr_pal][wr_idx] takes wr_rgb. There is no handshake, and back-to-back writes every cycle are legal.
- Lookup pipeline:
  - Stage 1 registers in_valid, in_idx and in_pal.
  - Stage 2 reads the table with the stage-1 values, applies the fade and registers the result.
  - Outputs change only when stage 2 is valid. When it is not valid, out_valid=0 and the colour outputs hold their last value.
- Transparency: when the stage-1 index is 0, out_transp=1 and RGB is forced to 0, regardless of the table contents and of fade.
- Fade arithmetic: each channel is c_out = (c > L) ? c − L : 0, where L = fade_level. The subtraction saturates and never wraps.
- Fade FSM states:
  - IDLE: L=0.
  - FADE_OUT: L increments by 1 each FADE_DIV cycles. Reaching 2^COLOR_W−1 moves to DARK.
  - DARK: L is held at its maximum.
  - FADE_IN: L decrements by 1 each FADE_DIV cycles. Reaching 0 moves to IDLE.
- Fade commands:
  - 01 in IDLE or FADE_IN enters FADE_OUT from the current L.
  - 10 in DARK or FADE_OUT enters FADE_IN from the current L.
  - A command matching the current direction or state is ignored.
  - Any accepted command clears the step prescaler.
- Out-of-range in_pal or wr_pal (only possible when NUM_PAL is not a power of two): the read returns 0 and the write is dropped.

## Timing
- Lookup latency is 2 cycles. A request with in_valid at edge N gives out_valid and data valid after edge N+2. Throughput is one pixel per cycle.
- Read-before-write: if a write and a stage-2 read hit the same entry at the same edge, the output carries the old value. The new value is visible to lookups sampled one edge later.
- The fade level used is the L registered before the stage-2 edge.
- A fade command sampled at edge N changes state at that edge. The first L change occurs FADE_DIV edges later.
- Reset values: out_valid=0, RGB=0, out_transp=0, fade_busy=0, fade_level=0, state=IDLE, prescaler=0, pipeline valids=0.
- Reset asserted mid-fade or mid-pipeline returns everything to those values asynchronously. Palette writes made before reset are lost.

## Structure
- Package sprite_palette_pkg holds:
  - fade_state_t enum (IDLE, FADE_OUT, DARK, FADE_IN)
  - fade_cmd encodings FADE_NONE, FADE_OUT_CMD, FADE_IN_CMD
  - DEFAULT_PAL constant, 16 × 12-bit
- Sub-module palette_fade_ctrl contains the FSM, prescaler and fade_level. The table and pipeline stay in the top level.

## Test plan
- Post-reset lookup with pal 0, idx 5 gives DEFAULT_PAL[5] after 2 cycles. Idx 0 gives out_transp=1 and RGB=000.
- Write pal 2 idx 3 = 0xA5C, then look it up gives A,5,C. Same-edge write and read of that entry returns the old value, and the next request returns 0xA5C.
- Streaming: 32 consecutive valid requests produce 32 consecutive out_valid cycles, in order, with 2-cycle latency. An in_valid gap produces a matching out_valid gap.
- Fade out with FADE_DIV=4 and entry 0xF93: L=1 after 4 cycles. At L=5 output is A,4,0. DARK is reached after 60 cycles with output 000 and fade_busy=0.
- fade_cmd=10 at L=7 during FADE_OUT reverses direction: L=6 after 4 cycles, then IDLE at L=0. A further 10 in IDLE is ignored.
- Reset asserted mid-FADE_OUT with pending valid pixels gives immediate out_valid=0, L=0 and state IDLE. The palette reverts to the defaults.
